sarlock_seq: RTL and testbench

Parametrised, sequential successor to the combinational SARLock wrapper. Protects an adder-based datapath of configurable width: the key is shifted in serially, held in a key register, and armed through a small load FSM. The locked result is produced through a registered, valid-qualified output stage. It sits between the key-provisioning scan port and the consumer of the protected circuit's outputs.

---
 rtl/sarlock_seq_if.sv | 18 +
 rtl/sarlock_seq.sv | 57 +++++
 tb/tb_sarlock_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sarlock_seq_if.sv
// sarlock_seq_if: key-load scan port and locked datapath bundle for sarlock_seq
interface sarlock_seq_if #(
  parameter int IN_W = 8,
  parameter int OUT_W = 2
);
  logic key_in, key_shift, key_clear, key_armed;
  logic in_valid, out_valid;
  logic [IN_W-1:0] inputs;
  logic [OUT_W-1:0] out;
  modport master(
    output key_in, key_shift, key_clear, in_valid, inputs,
    input key_armed, out_valid, out
  );
  modport slave(
    input key_in, key_shift, key_clear, in_valid, inputs,
    output key_armed, out_valid, out
  );
endinterface

// File: rtl/sarlock_seq.sv
// sarlock_seq: serial-keyed SARLock around a registered half-word adder
module sarlock_seq #(
  parameter int IN_W = 8,
  parameter int OUT_W = 2,
  parameter logic [IN_W-1:0] SECRET = 8'b01101101,
  parameter logic [OUT_W-1:0] FLIP_MASK = {OUT_W{1'b1}}
) (
  input logic clk,
  input logic rst,
  sarlock_seq_if.slave bus
);
  localparam int CW = $clog2(IN_W + 1);
  localparam int H = IN_W / 2;
  typedef enum logic [1:0] {UNKEYED, LOADING, ARMED} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic key_armed_q, key_armed_d, out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [H:0] sum;
  logic shift, flip, accept;
  always_comb begin
    shift = bus.key_shift && state_q != ARMED && cnt_q != CW'(IN_W);
    cnt_d = bus.key_clear ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    key_d = bus.key_clear ? '0 : shift ? {key_q[IN_W-2:0], bus.key_in} : key_q;
    state_d = bus.key_clear ? UNKEYED :
              (shift && cnt_d == CW'(IN_W)) ? ARMED :
              shift ? LOADING : state_q;
    key_armed_d = state_d == ARMED;
    sum = {1'b0, bus.inputs[H-1:0]} + {1'b0, bus.inputs[IN_W-1:H]};
    // flip compares against the key held before this edge, so a same-cycle clear still serves the beat
    flip = bus.inputs == key_q && bus.inputs != SECRET;
    accept = bus.in_valid && key_armed_q;
    out_d = accept ? sum[OUT_W-1:0] ^ (flip ? FLIP_MASK : '0) : out_q;
    out_valid_d = accept;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNKEYED;
      key_q <= '0;
      cnt_q <= '0;
      key_armed_q <= 1'b0;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
      key_armed_q <= key_armed_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.key_armed = key_armed_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out = out_q;
endmodule

// File: tb/tb_sarlock_seq.sv
// tb_sarlock_seq: random and directed checks of sarlock_seq against a behavioural model
module tb_sarlock_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic key_in = 1'b0, key_shift = 1'b0, key_clear = 1'b0, in_valid = 1'b0;
  logic [7:0] inputs = 8'h00;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_key = 8'h00;
  int m_cnt = 0;
  logic m_armed = 1'b0, m_ov = 1'b0;
  logic [1:0] m_out_a = 2'b00, m_out_b = 2'b00;

  always #5 clk = ~clk;

  sarlock_seq_if #(.IN_W(8), .OUT_W(2)) ifa ();
  sarlock_seq_if #(.IN_W(8), .OUT_W(2)) ifb ();
  assign ifa.key_in = key_in;
  assign ifa.key_shift = key_shift;
  assign ifa.key_clear = key_clear;
  assign ifa.in_valid = in_valid;
  assign ifa.inputs = inputs;
  assign ifb.key_in = key_in;
  assign ifb.key_shift = key_shift;
  assign ifb.key_clear = key_clear;
  assign ifb.in_valid = in_valid;
  assign ifb.inputs = inputs;

  sarlock_seq #(.FLIP_MASK(2'b11)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sarlock_seq #(.FLIP_MASK(2'b10)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic logic [1:0] locked(logic [7:0] x, logic [7:0] k, logic [1:0] mask);
    int s;
    logic [1:0] r;
    s = int'(x[3:0]) + int'(x[7:4]);
    r = 2'(s % 4);
    return (x == k && x != 8'h6D) ? r ^ mask : r;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the beat uses the pre-edge key, then the key register updates
  always @(posedge clk) begin
    if (rst) begin
      m_key = 8'h00; m_cnt = 0; m_armed = 1'b0; m_ov = 1'b0;
      m_out_a = 2'b00; m_out_b = 2'b00;
    end else begin
      m_ov = in_valid && m_armed;
      if (m_ov) begin
        m_out_a = locked(inputs, m_key, 2'b11);
        m_out_b = locked(inputs, m_key, 2'b10);
      end
      if (key_clear) begin
        m_key = 8'h00; m_cnt = 0; m_armed = 1'b0;
      end else if (key_shift && !m_armed) begin
        m_key = {m_key[6:0], key_in};
        m_cnt++;
        m_armed = m_cnt == 8;
      end
    end
  end

  always @(negedge clk) begin
    chk("armed_a", 32'(ifa.key_armed), 32'(m_armed));
    chk("armed_b", 32'(ifb.key_armed), 32'(m_armed));
    chk("ov_a", 32'(ifa.out_valid), 32'(m_ov));
    chk("ov_b", 32'(ifb.out_valid), 32'(m_ov));
    chk("out_a", 32'(ifa.out), 32'(m_out_a));
    chk("out_b", 32'(ifb.out), 32'(m_out_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(logic [7:0] k);
    for (int i = 7; i >= 0; i--) begin
      key_shift = 1'b1;
      key_in = k[i];
      tick();
      if (i == 1) chk("armed_after_7", 32'(ifa.key_armed), 32'd0);
      if (i == 0) chk("armed_after_8", 32'(ifa.key_armed), 32'd1);
    end
    key_shift = 1'b0;
  endtask

  task automatic beat(logic [7:0] x, logic [1:0] ea, logic [1:0] eb);
    in_valid = 1'b1;
    inputs = x;
    tick();
    in_valid = 1'b0;
    chk("beat_ov", 32'(ifa.out_valid), 32'd1);
    chk("beat_a", 32'(ifa.out), 32'(ea));
    chk("beat_b", 32'(ifb.out), 32'(eb));
  endtask

  initial begin
    in_valid = 1'b1;
    inputs = 8'h6D;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inputs = 8'($urandom);
      tick();
      chk("unarmed_ov", 32'(ifa.out_valid), 32'd0);
      chk("unarmed_out", 32'(ifa.out), 32'd0);
      chk("unarmed_armed", 32'(ifa.key_armed), 32'd0);
    end
    in_valid = 1'b0;
    load_key(8'h6D);
    beat(8'h6D, 2'b11, 2'b11);
    beat(8'h12, 2'b11, 2'b11);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    load_key(8'h12);
    beat(8'h12, 2'b00, 2'b01);
    beat(8'h34, 2'b11, 2'b11);
    beat(8'h6D, 2'b11, 2'b11);
    in_valid = 1'b1;
    foreach (ifb.out[j]) begin end
    inputs = 8'h12; tick(); chk("b2b0", 32'({ifb.out_valid, ifb.out}), 32'b101);
    inputs = 8'h34; tick(); chk("b2b1", 32'({ifb.out_valid, ifb.out}), 32'b111);
    inputs = 8'h12; tick(); chk("b2b2", 32'({ifb.out_valid, ifb.out}), 32'b101);
    in_valid = 1'b0;
    key_shift = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_in = 1'($urandom);
      tick();
    end
    key_shift = 1'b0;
    chk("armed_kept", 32'(ifa.key_armed), 32'd1);
    beat(8'h12, 2'b00, 2'b01);
    key_clear = 1'b1;
    key_shift = 1'b1;
    key_in = 1'b1;
    tick();
    key_clear = 1'b0;
    key_shift = 1'b0;
    chk("clear_wins", 32'(ifa.key_armed), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("no_accept_unkeyed", 32'(ifa.out_valid), 32'd0);
    load_key(8'h12);
    key_shift = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_in = 1'($urandom);
      tick();
    end
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_in = 1'($urandom);
      tick();
    end
    key_shift = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_key(8'h34);
    beat(8'h34, 2'b00, 2'b01);
    in_valid = 1'b1;
    inputs = 8'h34;
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    in_valid = 1'b0;
    chk("clear_same_beat", 32'({ifa.out_valid, ifa.out}), 32'b100);
    load_key(8'h34);
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_drop", 32'({ifa.out_valid, ifa.out, ifa.key_armed}), 32'd0);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      key_clear = $urandom_range(0, 79) == 0;
      key_shift = 1'($urandom);
      key_in = 1'($urandom);
      in_valid = 1'($urandom);
      inputs = ($urandom_range(0, 3) == 0) ? m_key :
               ($urandom_range(0, 7) == 0) ? 8'h6D : 8'($urandom);
      tick();
    end
    {rst, key_clear, key_shift, in_valid} = 4'b0000;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
